// File: rtl/snax_periph_pkg.sv
// Shared register map indices and job FSM state encoding for the SNAX peripheral register file.
package snax_periph_pkg;

    localparam int unsigned RegTrigger = 0;
    localparam int unsigned RegStatus  = 1;
    localparam int unsigned RegPerf    = 2;
    localparam int unsigned RegCfgBase = 3;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StRun
    } job_state_e;

endpackage

// File: rtl/hwpe_ctrl_intf_periph.sv
// Peripheral target bus: single-cycle grant request channel plus registered read response.
interface hwpe_ctrl_intf_periph #(
    parameter int unsigned IdWidth = 5
);

    logic               req;
    logic               gnt;
    logic [31:0]        add;
    logic               wen;
    logic [3:0]         be;
    logic [31:0]        data;
    logic [IdWidth-1:0] id;
    logic [31:0]        r_data;
    logic               r_valid;
    logic [IdWidth-1:0] r_id;

    modport master (
        output req, add, wen, be, data, id,
        input  gnt, r_data, r_valid, r_id
    );

    modport slave (
        input  req, add, wen, be, data, id,
        output gnt, r_data, r_valid, r_id
    );

endinterface

// File: rtl/snax_periph_job_fsm.sv
// Job sequencer (IDLE -> START -> RUN -> IDLE), sticky done flag and optional cycle counter.
// The counter exists only when SNAX_PERIPH_PERF_CNT_EN is defined; otherwise perf_o is 0.
module snax_periph_job_fsm
    import snax_periph_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        trigger_i,
    input  logic        done_i,
    input  logic        status_rd_i,
    output logic        start_o,
    output logic        busy_o,
    output logic        evt_o,
    output logic        done_o,
    output logic [31:0] perf_o
);

    job_state_e state_q;
    logic       start_q, busy_q, evt_q, done_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            evt_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            start_q <= 1'b0;
            evt_q   <= 1'b0;
            // A completion landing on the same edge as a STATUS read wins.
            if (status_rd_i) done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (trigger_i) begin
                        state_q <= StStart;
                        start_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                StStart: state_q <= StRun;
                StRun: begin
                    if (done_i) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                        evt_q   <= 1'b1;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign start_o = start_q;
    assign busy_o  = busy_q;
    assign evt_o   = evt_q;
    assign done_o  = done_q;

`ifdef SNAX_PERIPH_PERF_CNT_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_q <= '0;
        end else if (state_q == StStart) begin
            perf_q <= '0;
        end else if (state_q == StRun) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_o = perf_q;
`else
    assign perf_o = '0;
`endif

endmodule

// File: rtl/snax_periph_regfile.sv
// Memory-mapped control registers for a SNAX accelerator: TRIGGER, STATUS, PERF and CFG words.
// Optional feature macro: SNAX_PERIPH_PERF_CNT_EN (enables the PERF cycle counter).
module snax_periph_regfile
    import snax_periph_pkg::*;
#(
    parameter int unsigned NumRegs   = 8,
    parameter int unsigned DataWidth = 32
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    hwpe_ctrl_intf_periph.slave               periph,
    output logic [NumRegs-4:0][DataWidth-1:0] cfg_o,
    output logic                              start_o,
    input  logic                              done_i,
    output logic                              busy_o,
    output logic                              evt_o
);

    localparam int unsigned IdxW   = $clog2(NumRegs);
    localparam int unsigned NumCfg = NumRegs - RegCfgBase;

    logic [IdxW-1:0]                   idx;
    logic                              in_range, rd, wr;
    logic                              trigger, status_rd, cfg_we, done;
    logic [31:0]                       perf;
    logic [DataWidth-1:0]              rdata;
    logic [NumCfg-1:0][DataWidth-1:0]  cfg_q;
    logic                              unused_addr;

    assign unused_addr = ^periph.add[1:0];

    // Range check uses the full word address so aliases above NumRegs never hit a register.
    assign idx       = periph.add[2 +: IdxW];
    assign in_range  = periph.add[31:2] < 30'(NumRegs);
    assign rd        = periph.req & periph.wen;
    assign wr        = periph.req & ~periph.wen & in_range;
    assign trigger   = wr & (idx == IdxW'(RegTrigger)) & periph.be[0] & periph.data[0];
    assign status_rd = rd & in_range & (idx == IdxW'(RegStatus));
    assign cfg_we    = wr & ~busy_o;

    assign periph.gnt = periph.req;

    snax_periph_job_fsm u_job_fsm (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .trigger_i   (trigger),
        .done_i      (done_i),
        .status_rd_i (status_rd),
        .start_o     (start_o),
        .busy_o      (busy_o),
        .evt_o       (evt_o),
        .done_o      (done),
        .perf_o      (perf)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cfg_q <= '0;
        end else begin
            for (int i = 0; i < NumCfg; i++) begin
                if (cfg_we && idx == IdxW'(i + RegCfgBase)) begin
                    for (int b = 0; b < DataWidth / 8; b++) begin
                        if (periph.be[b]) cfg_q[i][8*b +: 8] <= periph.data[8*b +: 8];
                    end
                end
            end
        end
    end

    assign cfg_o = cfg_q;

    always_comb begin
        rdata = '0;
        if (in_range) begin
            if (idx == IdxW'(RegStatus)) begin
                rdata = {{(DataWidth-2){1'b0}}, done, busy_o};
            end else if (idx == IdxW'(RegPerf)) begin
                rdata = perf;
            end
            for (int i = 0; i < NumCfg; i++) begin
                if (idx == IdxW'(i + RegCfgBase)) rdata = cfg_q[i];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            periph.r_valid <= 1'b0;
            periph.r_data  <= '0;
            periph.r_id    <= '0;
        end else begin
            periph.r_valid <= rd;
            if (rd) begin
                periph.r_data <= rdata;
                periph.r_id   <= periph.id;
            end
        end
    end

endmodule

// File: tb/tb_snax_periph_regfile.sv
// Directed self-checking bench for snax_periph_regfile; PERF expectation follows
// SNAX_PERIPH_PERF_CNT_EN.
module tb_snax_periph_regfile;

    logic            clk;
    logic            rst_ni;
    logic            done_i;
    logic            start_o, busy_o, evt_o;
    logic [4:0][31:0] cfg_o;

    int n_checks = 0;
    int n_fail   = 0;

    hwpe_ctrl_intf_periph #(.IdWidth(5)) periph_if ();

    snax_periph_regfile #(
        .NumRegs   (8),
        .DataWidth (32)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_ni),
        .periph  (periph_if),
        .cfg_o   (cfg_o),
        .start_o (start_o),
        .done_i  (done_i),
        .busy_o  (busy_o),
        .evt_o   (evt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Each bus task starts at a falling edge and returns one falling edge later.
    task automatic bus_write(input int unsigned idx, input logic [31:0] data,
                             input logic [3:0] be);
        periph_if.req  = 1'b1;
        periph_if.wen  = 1'b0;
        periph_if.add  = 32'(idx) << 2;
        periph_if.be   = be;
        periph_if.data = data;
        periph_if.id   = '0;
        @(negedge clk);
        periph_if.req  = 1'b0;
    endtask

    task automatic bus_read(input int unsigned idx, input logic [4:0] id,
                            output logic [31:0] data, output logic [4:0] rid,
                            output logic valid);
        periph_if.req  = 1'b1;
        periph_if.wen  = 1'b1;
        periph_if.add  = 32'(idx) << 2;
        periph_if.be   = 4'hF;
        periph_if.data = '0;
        periph_if.id   = id;
        @(negedge clk);
        periph_if.req  = 1'b0;
        valid = periph_if.r_valid;
        data  = periph_if.r_data;
        rid   = periph_if.r_id;
    endtask

    logic [31:0] rd_data, exp_perf;
    logic [4:0]  rd_id;
    logic        rd_valid;
    int          extra_start;

    initial begin
`ifdef SNAX_PERIPH_PERF_CNT_EN
        exp_perf = 32'd10;
`else
        exp_perf = 32'd0;
`endif
        rst_ni         = 1'b0;
        done_i         = 1'b0;
        periph_if.req  = 1'b0;
        periph_if.wen  = 1'b1;
        periph_if.add  = '0;
        periph_if.be   = '0;
        periph_if.data = '0;
        periph_if.id   = '0;
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_busy", 32'(busy_o), 32'd0);
        check_eq("rst_start", 32'(start_o), 32'd0);
        check_eq("rst_evt", 32'(evt_o), 32'd0);
        check_eq("rst_rvalid", 32'(periph_if.r_valid), 32'd0);
        check_eq("rst_rdata", periph_if.r_data, 32'd0);
        check_eq("rst_rid", 32'(periph_if.r_id), 32'd0);
        for (int i = 0; i < 5; i++) check_eq($sformatf("rst_cfg%0d", i), cfg_o[i], 32'd0);
        rst_ni = 1'b1;
        @(negedge clk);

        // Full-word CFG write then read with id
        bus_write(3, 32'hA5A5_0001, 4'hF);
        check_eq("wr_no_rvalid", 32'(periph_if.r_valid), 32'd0);
        check_eq("cfg_o0", cfg_o[0], 32'hA5A5_0001);
        periph_if.req = 1'b1;
        #1 check_eq("gnt_eq_req", 32'(periph_if.gnt), 32'd1);
        bus_read(3, 5'd7, rd_data, rd_id, rd_valid);
        check_eq("rd3_valid", 32'(rd_valid), 32'd1);
        check_eq("rd3_data", rd_data, 32'hA5A5_0001);
        check_eq("rd3_id", 32'(rd_id), 32'd7);

        // Byte-lane enables
        bus_write(4, 32'h1122_3344, 4'b0101);
        bus_read(4, 5'd1, rd_data, rd_id, rd_valid);
        check_eq("rd4_be", rd_data, 32'h0022_0044);

        // Back-to-back reads, one response per cycle
        periph_if.req = 1'b1;
        periph_if.wen = 1'b1;
        periph_if.add = 32'd3 << 2;
        periph_if.id  = 5'd1;
        @(negedge clk);
        check_eq("b2b_v1", 32'(periph_if.r_valid), 32'd1);
        check_eq("b2b_d1", periph_if.r_data, 32'hA5A5_0001);
        check_eq("b2b_i1", 32'(periph_if.r_id), 32'd1);
        periph_if.add = 32'd4 << 2;
        periph_if.id  = 5'd2;
        @(negedge clk);
        periph_if.req = 1'b0;
        check_eq("b2b_v2", 32'(periph_if.r_valid), 32'd1);
        check_eq("b2b_d2", periph_if.r_data, 32'h0022_0044);
        check_eq("b2b_i2", 32'(periph_if.r_id), 32'd2);

        // Out-of-range accesses (index 11 aliases reg3 in the low bits)
        bus_write(11, 32'hFFFF_FFFF, 4'hF);
        check_eq("oor_wr_cfg0", cfg_o[0], 32'hA5A5_0001);
        bus_read(9, 5'd4, rd_data, rd_id, rd_valid);
        check_eq("oor_rd_valid", 32'(rd_valid), 32'd1);
        check_eq("oor_rd_data", rd_data, 32'd0);
        check_eq("trig_rd", 32'd0, 32'd0 | 32'(busy_o));

        // Job 1: trigger, ignored writes while running, done after 10 RUN cycles
        bus_write(0, 32'd1, 4'hF);
        check_eq("j1_start", 32'(start_o), 32'd1);
        check_eq("j1_busy", 32'(busy_o), 32'd1);
        bus_write(0, 32'd1, 4'hF);
        check_eq("j1_start_1cyc", 32'(start_o), 32'd0);
        bus_write(3, 32'hDEAD_BEEF, 4'hF);
        check_eq("j1_cfg_locked", cfg_o[0], 32'hA5A5_0001);
        bus_write(0, 32'd1, 4'hF);
        extra_start = 32'(start_o);
        repeat (7) begin
            @(negedge clk);
            extra_start += 32'(start_o) + 32'(evt_o);
        end
        check_eq("j1_no_restart", 32'(extra_start), 32'd0);
        check_eq("j1_busy_run", 32'(busy_o), 32'd1);
        done_i = 1'b1;
        @(negedge clk);
        done_i = 1'b0;
        check_eq("j1_evt", 32'(evt_o), 32'd1);
        check_eq("j1_idle", 32'(busy_o), 32'd0);
        @(negedge clk);
        check_eq("j1_evt_1cyc", 32'(evt_o), 32'd0);
        bus_read(1, 5'd0, rd_data, rd_id, rd_valid);
        check_eq("j1_status_done", rd_data, 32'h2);
        bus_read(1, 5'd0, rd_data, rd_id, rd_valid);
        check_eq("j1_status_clr", rd_data, 32'h0);
        bus_read(2, 5'd0, rd_data, rd_id, rd_valid);
        check_eq("j1_perf", rd_data, exp_perf);
        bus_read(3, 5'd0, rd_data, rd_id, rd_valid);
        check_eq("j1_reg3_kept", rd_data, 32'hA5A5_0001);

        // done_i outside RUN is ignored
        done_i = 1'b1;
        @(negedge clk);
        done_i = 1'b0;
        check_eq("idle_done_evt", 32'(evt_o), 32'd0);
        bus_read(1, 5'd0, rd_data, rd_id, rd_valid);
        check_eq("idle_done_status", rd_data, 32'h0);

        // Job 2: STATUS read in the done_i cycle sees done=0, done stays set
        bus_write(0, 32'd1, 4'hF);
        @(negedge clk);
        done_i = 1'b1;
        bus_read(1, 5'd0, rd_data, rd_id, rd_valid);
        done_i = 1'b0;
        check_eq("j2_coincide_status", rd_data, 32'h1);
        check_eq("j2_evt", 32'(evt_o), 32'd1);
        bus_read(1, 5'd0, rd_data, rd_id, rd_valid);
        check_eq("j2_status_after", rd_data, 32'h2);

        // Job 3: asynchronous reset mid-job
        bus_write(3, 32'h1234_5678, 4'hF);
        bus_write(0, 32'd1, 4'hF);
        bus_read(3, 5'd3, rd_data, rd_id, rd_valid);
        check_eq("j3_rd", rd_data, 32'h1234_5678);
        rst_ni = 1'b0;
        #1;
        check_eq("j3_rst_busy", 32'(busy_o), 32'd0);
        check_eq("j3_rst_cfg0", cfg_o[0], 32'd0);
        check_eq("j3_rst_rvalid", 32'(periph_if.r_valid), 32'd0);
        check_eq("j3_rst_rdata", periph_if.r_data, 32'd0);
        check_eq("j3_rst_rid", 32'(periph_if.r_id), 32'd0);
        @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);
        bus_read(1, 5'd0, rd_data, rd_id, rd_valid);
        check_eq("j3_status_after_rst", rd_data, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
